tap_ir_controller: RTL and testbench

IEEE 1149.1 TAP state machine plus instruction register and decoder. Sequences the test logic by walking the 16-state TAP FSM on TMS, capturing, shifting and updating the IR, and driving the DR control strobes. It is the source of `tap_reset`, `update_ir`, `bypass_decode`, `clamp_hold_decode`, `clamp_release_decode` and `bypass_escape` consumed by the TMP controller.

---
 rtl/tap_ir_controller.sv | 90 +++++++++
 tb/tb_tap_ir_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tap_ir_controller.sv
// tap_ir_controller: IEEE 1149.1 TAP FSM with instruction register, opcode decodes
// and a bypass-escape detector (2*IR_WIDTH consecutive ones shifted into the IR).
module tap_ir_controller #(
  parameter int                  IR_WIDTH         = 4,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS        = '1,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE        = IR_WIDTH'('b0001),
  parameter logic [IR_WIDTH-1:0] OP_CLAMP_HOLD    = IR_WIDTH'('b0101),
  parameter logic [IR_WIDTH-1:0] OP_CLAMP_RELEASE = IR_WIDTH'('b0110)
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                dr_tdo,
  output logic                tdo,
  output logic                tdo_en,
  output logic                tap_reset,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                update_ir,
  output logic [IR_WIDTH-1:0] ir,
  output logic                bypass_decode,
  output logic                clamp_hold_decode,
  output logic                clamp_release_decode,
  output logic                bypass_escape
);
  localparam int CW = $clog2(2*IR_WIDTH)+1;
  localparam logic [CW-1:0] ESC_MAX = CW'(2*IR_WIDTH);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } state_t;
  state_t              r_state, w_next;
  logic [IR_WIDTH-1:0] r_ir_sr, r_ir;
  logic [CW-1:0]       r_esc;
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:      w_next = TMS ? TLR      : RTI;
      RTI:      w_next = TMS ? SEL_DR   : RTI;
      SEL_DR:   w_next = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   w_next = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: w_next = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: w_next = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: w_next = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: w_next = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   w_next = TMS ? SEL_DR   : RTI;
      SEL_IR:   w_next = TMS ? TLR      : CAP_IR;
      CAP_IR:   w_next = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: w_next = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: w_next = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: w_next = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: w_next = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   w_next = TMS ? SEL_DR   : RTI;
      default:  w_next = TLR;
    endcase
  end
  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_state <= TLR;
      r_ir_sr <= '0;
      r_ir    <= OP_IDCODE;
      r_esc   <= '0;
    end else begin
      r_state <= w_next;
      r_ir_sr <= r_state == CAP_IR   ? IR_WIDTH'(2'b01) :
                 r_state == SHIFT_IR ? {TDI, r_ir_sr[IR_WIDTH-1:1]} : r_ir_sr;
      r_ir    <= r_state == TLR    ? OP_IDCODE :
                 r_state == UPD_IR ? r_ir_sr : r_ir;
      // the run of ones only counts while shifting; any zero restarts it
      r_esc   <= (r_state == CAP_IR || r_state == TLR) ? '0 :
                 r_state != SHIFT_IR ? r_esc :
                 !TDI ? '0 :
                 r_esc == ESC_MAX ? r_esc : r_esc + CW'(1);
    end
  end
  assign tdo                  = r_state == SHIFT_IR ? r_ir_sr[0] : r_state == SHIFT_DR ? dr_tdo : 1'b0;
  assign tdo_en               = r_state == SHIFT_IR || r_state == SHIFT_DR;
  assign tap_reset            = r_state == TLR;
  assign capture_dr           = r_state == CAP_DR;
  assign shift_dr             = r_state == SHIFT_DR;
  assign update_dr            = r_state == UPD_DR;
  assign update_ir            = r_state == UPD_IR;
  assign ir                   = r_ir;
  assign bypass_decode        = r_ir == OP_BYPASS;
  assign clamp_hold_decode    = r_ir == OP_CLAMP_HOLD;
  assign clamp_release_decode = r_ir == OP_CLAMP_RELEASE;
  assign bypass_escape        = r_esc == ESC_MAX;
endmodule

// File: tb/tb_tap_ir_controller.sv
// tb_tap_ir_controller: directed TMS/TDI walk; expectations queued per step and
// checked right after the clock edge that should produce them.
module tb_tap_ir_controller;
  logic TCK = 1'b0, TRST = 1'b0, TMS = 1'b1, TDI = 1'b0, dr_tdo = 1'b0;
  logic tdo, tdo_en, tap_reset, capture_dr, shift_dr, update_dr, update_ir;
  logic [3:0] ir;
  logic bypass_decode, clamp_hold_decode, clamp_release_decode, bypass_escape;
  tap_ir_controller dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .dr_tdo(dr_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .tap_reset(tap_reset), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .update_ir(update_ir), .ir(ir),
    .bypass_decode(bypass_decode), .clamp_hold_decode(clamp_hold_decode),
    .clamp_release_decode(clamp_release_decode), .bypass_escape(bypass_escape)
  );
  always #5 TCK = ~TCK;
  localparam int ST = 0, TD = 1, IRV = 2, DEC = 3, ESC = 4;
  // strobe vector {tap_reset, capture_dr, shift_dr, update_dr, update_ir, tdo_en}
  localparam logic [15:0] S_NONE = 16'b000000, S_TLR = 16'b100000, S_CAPDR = 16'b010000,
                          S_SHDR = 16'b001001, S_UPDR = 16'b000100, S_UPIR = 16'b000010,
                          S_SHIR = 16'b000001;
  typedef struct { string tag; int sel; logic [15:0] v; } ent_t;
  ent_t sb[$];
  int n_pass = 0, n_chk = 0;
  function automatic logic [15:0] obs(input int sel);
    return sel == ST  ? {10'b0, tap_reset, capture_dr, shift_dr, update_dr, update_ir, tdo_en} :
           sel == TD  ? {15'b0, tdo} :
           sel == IRV ? {12'b0, ir} :
           sel == DEC ? {13'b0, bypass_decode, clamp_hold_decode, clamp_release_decode} :
                        {15'b0, bypass_escape};
  endfunction
  function automatic logic [15:0] dec_of(input logic [3:0] v);
    return {13'b0, v == 4'hF, v == 4'h5, v == 4'h6};
  endfunction
  task automatic want(input string tag, input int sel, input logic [15:0] v);
    sb.push_back('{tag, sel, v});
  endtask
  task automatic go(input logic tms, input logic tdi);
    ent_t e;
    logic [15:0] o;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_chk++;
      assert (o === e.v) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
    end
  endtask
  // from RTI: walk to Shift-IR, shift n bits LSB first, end in Exit1-IR
  task automatic shift_ir(input logic [15:0] bits, input int n, input logic [15:0] tdo_exp,
                          input bit chk_tdo, input logic esc_last);
    want("sel_dr", ST, S_NONE);  go(1, 0);
    want("sel_ir", ST, S_NONE);  go(1, 0);
    want("cap_ir", ST, S_NONE);  go(0, 0);
    want("shift_ir", ST, S_SHIR);
    want("esc_cap_clr", ESC, 0);
    if (chk_tdo) want("tdo0", TD, {15'b0, tdo_exp[0]});
    go(0, 0);
    for (int i = 0; i < n; i++) begin
      want("shift_st", ST, i == n-1 ? S_NONE : S_SHIR);
      want("esc", ESC, i == n-1 ? {15'b0, esc_last} : 16'h0);
      if (chk_tdo && i < n-1) want("tdo", TD, {15'b0, tdo_exp[i+1]});
      go(i == n-1, bits[i]);
    end
  endtask
  // from Exit1-IR: through Update-IR into RTI
  task automatic upd(input logic [3:0] old_ir, input logic [3:0] new_ir, input logic esc);
    want("upd_ir", ST, S_UPIR);
    want("upd_ir_old", IRV, {12'b0, old_ir});
    want("upd_dec_old", DEC, dec_of(old_ir));
    want("upd_esc", ESC, {15'b0, esc});
    go(1, 0);
    want("rti", ST, S_NONE);
    want("ir_new", IRV, {12'b0, new_ir});
    want("dec_new", DEC, dec_of(new_ir));
    want("rti_esc", ESC, {15'b0, esc});
    go(0, 0);
  endtask
  initial begin
    TRST = 1;
    want("rst_st", ST, S_TLR); want("rst_ir", IRV, 16'h1); want("rst_dec", DEC, 0);
    want("rst_esc", ESC, 0); want("rst_tdo", TD, 0);
    go(1, 0);
    TRST = 0;
    want("rti", ST, S_NONE);     go(0, 0);
    want("seldr", ST, S_NONE);   go(1, 0);
    want("capdr", ST, S_CAPDR);  go(0, 0);
    dr_tdo = 1;
    want("shdr", ST, S_SHDR); want("shdr_tdo1", TD, 1); go(0, 0);
    dr_tdo = 0;
    want("shdr2", ST, S_SHDR); want("shdr_tdo0", TD, 0); go(0, 0);
    TRST = 1;
    want("midrst_st", ST, S_TLR); want("midrst_ir", IRV, 16'h1); go(0, 0);
    TRST = 0;
    want("rti", ST, S_NONE);     go(0, 0);
    for (int i = 0; i < 5; i++) begin
      want("tms5", ST, i < 2 ? S_NONE : S_TLR);
      go(1, 0);
    end
    // all 16 states
    want("w_rti", ST, S_NONE);     go(0, 0);
    want("w_seldr", ST, S_NONE);   go(1, 0);
    want("w_capdr", ST, S_CAPDR);  go(0, 0);
    want("w_shdr", ST, S_SHDR);    go(0, 0);
    want("w_ex1dr", ST, S_NONE);   go(1, 0);
    want("w_psdr", ST, S_NONE);    go(0, 0);
    want("w_ex2dr", ST, S_NONE);   go(1, 0);
    want("w_shdr2", ST, S_SHDR);   go(0, 0);
    want("w_ex1dr2", ST, S_NONE);  go(1, 0);
    want("w_upddr", ST, S_UPDR);   go(1, 0);
    want("w_seldr2", ST, S_NONE);  go(1, 0);
    want("w_selir", ST, S_NONE);   go(1, 0);
    want("w_capir", ST, S_NONE);   go(0, 0);
    want("w_shir", ST, S_SHIR);    go(0, 0);
    want("w_ex1ir", ST, S_NONE);   go(1, 0);
    want("w_psir", ST, S_NONE);    go(0, 0);
    want("w_ex2ir", ST, S_NONE);   go(1, 0);
    want("w_shir2", ST, S_SHIR);   go(0, 0);
    want("w_ex1ir2", ST, S_NONE);  go(1, 0);
    want("w_updir", ST, S_UPIR);   go(1, 0);
    want("w_rti2", ST, S_NONE);    go(0, 0);
    // IR loads; the walk left ir = 0000
    shift_ir(16'b1010, 4, 16'b0001, 1, 0);  upd(4'h0, 4'hA, 0);
    shift_ir(16'b0101, 4, 0, 0, 0);         upd(4'hA, 4'h5, 0);
    shift_ir(16'b0110, 4, 0, 0, 0);         upd(4'h5, 4'h6, 0);
    shift_ir(16'hFF, 8, 0, 0, 1);           upd(4'h6, 4'hF, 1);
    shift_ir(16'h7F, 8, 0, 0, 0);           upd(4'hF, 4'h7, 0);
    shift_ir(16'b1111, 4, 0, 0, 0);         upd(4'h7, 4'hF, 0);
    shift_ir(16'b0101, 4, 0, 0, 0);         upd(4'hF, 4'h5, 0);
    want("tlr_a", ST, S_NONE);  go(1, 0);
    want("tlr_b", ST, S_NONE);  go(1, 0);
    want("tlr_c", ST, S_TLR);   go(1, 0);
    want("tlr_st", ST, S_TLR); want("tlr_ir", IRV, 16'h1); want("tlr_dec", DEC, 0);
    go(1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
